// File: rtl/led_addr_gen_if.sv
// led_addr_gen_if -- control/ROM-side bundle for led_addr_gen.
// master: the controller driving playback commands and watching the ROM port.
// slave : the address generator itself.
interface led_addr_gen_if;
  logic        start;
  logic        stop;
  logic        hold;
  logic        dir;
  logic [11:0] addr;
  logic        en;
  logic        step;
  logic        wrap;

  modport master (output start, stop, hold, dir,
                  input  addr, en, step, wrap);
  modport slave  (input  start, stop, hold, dir,
                  output addr, en, step, wrap);
endinterface

// File: rtl/led_addr_gen.sv
// led_addr_gen -- pattern ROM address sequencer for LED playback.
// IDLE/RUN/PAUSE controller stepping a 12-bit address once every PRESCALE
// clocks, up or down, with step/wrap pulses aligned to each address update.
// Optional feature: define LED_ADDR_GEN_DEBOUNCE_EN to pass hold and dir
// through a 2-flop synchronizer plus a DEBOUNCE_CYCLES stability filter.
module led_addr_gen #(
  parameter int PRESCALE        = 50000000,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic          clk,
  input  logic          rst_n,
  led_addr_gen_if.slave bus
);

  localparam int PSC_W = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;

  // Reject out-of-range configurations at elaboration.
  if (PRESCALE < 2 || PRESCALE > (1 << 26) || DEBOUNCE_CYCLES < 1) begin : g_bad_param
    $error("led_addr_gen: illegal PRESCALE/DEBOUNCE_CYCLES");
  end

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  logic hold_i, dir_i;

`ifdef LED_ADDR_GEN_DEBOUNCE_EN
  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

  // bit 0 = hold, bit 1 = dir
  logic [1:0]           raw, sync1, sync2, filt;
  logic [1:0][DB_W-1:0] db_cnt;

  assign raw = {bus.dir, bus.hold};

  // Two-flop synchronizer ahead of the filters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Filter output follows the synchronized value only after it has
  // disagreed with the output for DEBOUNCE_CYCLES samples in a row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt <= '0;
      filt   <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == filt[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          db_cnt[i] <= '0;
          filt[i]   <= sync2[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  assign hold_i = filt[0];
  assign dir_i  = filt[1];
`else
  assign hold_i = bus.hold;
  assign dir_i  = bus.dir;
`endif

  state_t             state, state_nxt;
  logic [PSC_W-1:0]   psc, psc_nxt;
  logic [11:0]        addr_q, addr_nxt;
  logic               en_q, en_nxt;
  logic               step_q, step_nxt;
  logic               wrap_q, wrap_nxt;
  logic               tick;

  assign tick = (psc == PSC_W'(PRESCALE - 1));

  // State and all outputs are registered together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      psc    <= '0;
      addr_q <= '0;
      en_q   <= 1'b0;
      step_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      psc    <= psc_nxt;
      addr_q <= addr_nxt;
      en_q   <= en_nxt;
      step_q <= step_nxt;
      wrap_q <= wrap_nxt;
    end
  end

  // Next state: stop beats start beats hold beats tick. PAUSE simply
  // withholds prescaler advance, so counts resume where they left off.
  always_comb begin
    state_nxt = state;
    psc_nxt   = psc;
    addr_nxt  = addr_q;
    en_nxt    = en_q;
    step_nxt  = 1'b0;
    wrap_nxt  = 1'b0;
    unique case (state)
      IDLE: begin
        en_nxt   = 1'b0;
        addr_nxt = '0;
        psc_nxt  = '0;
        if (bus.start && !bus.stop) begin
          state_nxt = RUN;
          en_nxt    = 1'b1;
        end
      end
      RUN, PAUSE: begin
        en_nxt = 1'b1;
        if (bus.stop) begin
          state_nxt = IDLE;
          en_nxt    = 1'b0;
          addr_nxt  = '0;
          psc_nxt   = '0;
        end else if (hold_i) begin
          state_nxt = PAUSE;
        end else begin
          state_nxt = RUN;
          if (tick) begin
            psc_nxt  = '0;
            step_nxt = 1'b1;
            addr_nxt = dir_i ? addr_q - 12'd1 : addr_q + 12'd1;
            wrap_nxt = dir_i ? (addr_q == 12'd0) : (addr_q == 12'hFFF);
          end else begin
            psc_nxt = psc + PSC_W'(1);
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        en_nxt    = 1'b0;
        addr_nxt  = '0;
        psc_nxt   = '0;
      end
    endcase
  end

  assign bus.addr = addr_q;
  assign bus.en   = en_q;
  assign bus.step = step_q;
  assign bus.wrap = wrap_q;

endmodule

// File: tb/tb_led_addr_gen.sv
// tb_led_addr_gen -- directed bench for led_addr_gen (PRESCALE=4,
// DEBOUNCE_CYCLES=3). Inputs change and outputs are sampled 1 ns after
// each rising edge. Timing expectations differ when
// LED_ADDR_GEN_DEBOUNCE_EN is defined.
module tb_led_addr_gen;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;
  int   bad;

  led_addr_gen_if bus ();

  led_addr_gen #(.PRESCALE(4), .DEBOUNCE_CYCLES(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic go();
    bus.start = 1'b1;
    cyc(1);
    bus.start = 1'b0;
  endtask

  task automatic halt();
    bus.stop = 1'b1;
    cyc(1);
    bus.stop = 1'b0;
  endtask

  // Run until a step lands on address a, bounded by budget cycles.
  task automatic run_to(input int a, input int budget);
    int k;
    k = 0;
    while (!(bus.step && int'(bus.addr) == a) && k < budget) begin
      cyc(1);
      k++;
    end
    chk("reach_addr", int'(k < budget), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0;
    n_pass = 0;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    bus.hold  = 1'b0;
    bus.dir   = 1'b0;
    cyc(3);
    chk("rst_addr", int'(bus.addr), 0);
    chk("rst_en",   int'(bus.en),   0);
    chk("rst_step", int'(bus.step), 0);
    chk("rst_wrap", int'(bus.wrap), 0);
    rst_n = 1'b1;
    cyc(2);

    // start -> en on the next cycle; steps every 4 cycles after entry
    go();
    chk("entry_en",   int'(bus.en),   1);
    chk("entry_addr", int'(bus.addr), 0);
    chk("entry_step", int'(bus.step), 0);
    cyc(3);
    chk("pre_step1",  int'(bus.step), 0);
    cyc(1);
    chk("step1",      int'(bus.step), 1);
    chk("step1_addr", int'(bus.addr), 1);
    chk("step1_wrap", int'(bus.wrap), 0);
    cyc(1);
    chk("step1_pulse", int'(bus.step), 0);
    cyc(3);
    chk("step2",      int'(bus.step), 1);
    chk("step2_addr", int'(bus.addr), 2);
    cyc(4);
    chk("step3",      int'(bus.step), 1);
    chk("step3_addr", int'(bus.addr), 3);
    halt();
    chk("stop_en",   int'(bus.en),   0);
    chk("stop_addr", int'(bus.addr), 0);

    // wrap in both directions
    bus.dir = 1'b1;
    cyc(8);
    go();
    cyc(4);
    chk("wrap_dn_addr", int'(bus.addr), 4095);
    chk("wrap_dn_step", int'(bus.step), 1);
    chk("wrap_dn_wrap", int'(bus.wrap), 1);
    bus.dir = 1'b0;
`ifdef LED_ADDR_GEN_DEBOUNCE_EN
    cyc(4);
    chk("dir_lag_addr", int'(bus.addr), 4094);
    cyc(4);
    chk("dir_new_addr", int'(bus.addr), 4095);
    chk("dir_new_wrap", int'(bus.wrap), 0);
`endif
    cyc(4);
    chk("wrap_up_addr", int'(bus.addr), 0);
    chk("wrap_up_step", int'(bus.step), 1);
    chk("wrap_up_wrap", int'(bus.wrap), 1);
    cyc(4);
    chk("post_wrap_addr", int'(bus.addr), 1);
    chk("post_wrap_wrap", int'(bus.wrap), 0);
    halt();

`ifdef LED_ADDR_GEN_DEBOUNCE_EN
    // 2-cycle glitch is filtered; 6-cycle hold delays the step by 6
    go();
    bus.hold = 1'b1;
    cyc(2);
    bus.hold = 1'b0;
    cyc(2);
    chk("glitch_step", int'(bus.step), 1);
    chk("glitch_addr", int'(bus.addr), 1);
    bus.hold = 1'b1;
    cyc(4);
    chk("lat_step", int'(bus.step), 1);
    chk("lat_addr", int'(bus.addr), 2);
    cyc(2);
    bus.hold = 1'b0;
    cyc(2);
    chk("paused_step", int'(bus.step), 0);
    chk("paused_addr", int'(bus.addr), 2);
    cyc(6);
    chk("resume_step", int'(bus.step), 1);
    chk("resume_addr", int'(bus.addr), 3);
    halt();
`else
    // hold after two counts freezes; two cycles after release it steps
    go();
    cyc(2);
    bus.hold = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      if (bus.step || bus.addr != 12'd0 || !bus.en) bad++;
    end
    chk("hold_frozen", bad, 0);
    bus.hold = 1'b0;
    cyc(1);
    chk("resume_early", int'(bus.step), 0);
    cyc(1);
    chk("resume_step", int'(bus.step), 1);
    chk("resume_addr", int'(bus.addr), 1);
    halt();
`endif

    // stop on the tick cycle at addr 7 suppresses the step
    go();
    run_to(7, 60);
    cyc(3);
    chk("tick7_addr", int'(bus.addr), 7);
    bus.stop = 1'b1;
    cyc(1);
    bus.stop = 1'b0;
    chk("stoptick_step", int'(bus.step), 0);
    chk("stoptick_wrap", int'(bus.wrap), 0);
    chk("stoptick_addr", int'(bus.addr), 0);
    chk("stoptick_en",   int'(bus.en),   0);
    cyc(5);
    chk("idle_en", int'(bus.en), 0);
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    cyc(1);
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    chk("startstop_en", int'(bus.en), 0);
    cyc(4);
    chk("startstop_en2", int'(bus.en), 0);
    bus.hold = 1'b1;
    cyc(3);
    chk("idle_hold_en", int'(bus.en), 0);
    bus.hold = 1'b0;
    cyc(8);

    // async reset mid-run at addr 100
    go();
    run_to(100, 500);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_addr", int'(bus.addr), 0);
    chk("async_en",   int'(bus.en),   0);
    chk("async_step", int'(bus.step), 0);
    cyc(2);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      cyc(1);
      if (bus.step || bus.wrap || bus.en) bad++;
    end
    chk("post_rst_quiet", bad, 0);
    go();
    cyc(4);
    chk("restart_step", int'(bus.step), 1);
    chk("restart_addr", int'(bus.addr), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
